ripple_borrow_subtract_serial: RTL

Digit-serial fixed-point subtractor in the FixedPointArithmetic IP, Add unit family. Computes c = a − b − bi over N bits, K bits per clock, using a ripple-borrow chain within each digit and a registered borrow between digits. It uses valid/ready handshakes on both sides and is the area-lean counterpart to the single-cycle adders, for datapaths that trade latency for gate count.

---
 rtl/ripple_borrow_subtract_serial.sv | 106 ++++++++++
 1 files changed

// File: rtl/ripple_borrow_subtract_serial.sv
// Digit-serial subtractor c = a - b - bi, K bits per cycle, registered borrow between digits.
// Latency N/K cycles from accept to out_valid; define SUB_OVERFLOW_FLAG_EN to add the signed-overflow output v.
// Backpressure: result, flags and out_valid hold in DONE until out_ready; no operands are accepted outside IDLE.
module ripple_borrow_subtract_serial #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
`ifdef SUB_OVERFLOW_FLAG_EN
    output logic         v,
`endif
    output logic         bo
);

    localparam int D  = N / K;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    a_q, b_q;
    logic            borrow_q;
    logic [N-1:0]    c_q;
    logic [K-1:0]    a_dig, b_dig;
    logic [K:0]      sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)      state_d = RUN;
            RUN:  if (cnt_q == LAST) state_d = DONE;
            DONE: if (out_ready)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Operands stay in place; the active digit is picked by the counter.
    always_comb begin
        a_dig = a_q[cnt_q*K +: K];
        b_dig = b_q[cnt_q*K +: K];
        sum   = {1'b0, a_dig} + {1'b0, ~b_dig} + {{K{1'b0}}, ~borrow_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            c_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    borrow_q <= bi;
                    cnt_q    <= '0;
                end
                RUN: begin
                    c_q[cnt_q*K +: K] <= sum[K-1:0];
                    borrow_q          <= ~sum[K];
                    cnt_q             <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVERFLOW_FLAG_EN
    logic v_q;
    // The last digit carries the sign bit, so its fresh MSB is c[N-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            v_q <= 1'b0;
        else if (state_q == RUN && cnt_q == LAST)
            v_q <= (a_q[N-1] != b_q[N-1]) && (sum[K-1] != a_q[N-1]);
    end
    assign v = v_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign bo        = borrow_q;

endmodule
